// File: rtl/pipe3_if.sv
// Instruction-fetch and write-back bus of the pipe3 core.
// The core drives the master side; instruction memory and observers sit on the slave side.
interface pipe3_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int PC_W   = 8
);
  localparam int REG_AW  = $clog2(NREG);
  localparam int INSTR_W = 3 + 2 * REG_AW;

  logic [PC_W-1:0]    pc_o;
  logic [INSTR_W-1:0] instr_i;
  logic [DATA_W-1:0]  imm_i;
  logic               instr_valid_i;
  logic               wb_en_o;
  logic [REG_AW-1:0]  wb_addr_o;
  logic [DATA_W-1:0]  wb_data_o;
  logic               halted_o;

  modport master (
    output pc_o, wb_en_o, wb_addr_o, wb_data_o, halted_o,
    input  instr_i, imm_i, instr_valid_i
  );

  modport slave (
    input  pc_o, wb_en_o, wb_addr_o, wb_data_o, halted_o,
    output instr_i, imm_i, instr_valid_i
  );
endinterface

// File: rtl/pipe3_core.sv
// Parametrised 3-stage integer pipeline: IF, ID (register read + forwarding), EX/WB.
// JMP resolves in IF; BZ resolves in EX and squashes the two younger slots.
module pipe3_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int PC_W   = 8
) (
  input logic      clk,
  input logic      rst,
  pipe3_if.master  bus
);
  localparam int REG_AW  = $clog2(NREG);
  localparam int INSTR_W = 3 + 2 * REG_AW;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MOVI = 3'd1,
    OP_ADDI = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_JMP  = 3'd5,
    OP_BZ   = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
  } ifid_t;

  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] a;    // rd operand
    logic [DATA_W-1:0] b;    // rs operand
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
  } idex_t;

  logic [PC_W-1:0]   pc, pc_nx;
  logic              fetch_stop, fetch_stop_nx;
  ifid_t             ifid, ifid_nx;
  idex_t             idex, idex_nx;
  logic [DATA_W-1:0] regs [NREG];

  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              halted;

  op_e               f_op;
  logic [REG_AW-1:0] f_rd, f_rs;
  logic [DATA_W-1:0] ex_result;
  logic              ex_wr;
  logic              bz_taken;
  logic [PC_W-1:0]   bz_target, jmp_target;
  logic [DATA_W-1:0] id_a, id_b;

  assign f_op = op_e'(bus.instr_i[INSTR_W-1 -: 3]);
  assign f_rd = bus.instr_i[2*REG_AW-1 -: REG_AW];
  assign f_rs = bus.instr_i[REG_AW-1:0];

  // Signed size casts sign-extend the immediate when PC_W > DATA_W and truncate otherwise.
  assign jmp_target = pc + PC_W'($signed(bus.imm_i));
  assign bz_target  = idex.pc + PC_W'($signed(idex.imm));
  assign bz_taken   = (idex.op == OP_BZ) && (idex.b == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ex_result = idex.a;
    ex_wr     = 1'b0;
    case (idex.op)
      OP_MOVI: begin ex_result = idex.imm;          ex_wr = 1'b1; end
      OP_ADDI: begin ex_result = idex.a + idex.imm; ex_wr = 1'b1; end
      OP_ADD:  begin ex_result = idex.a + idex.b;   ex_wr = 1'b1; end
      OP_SUB:  begin ex_result = idex.a - idex.b;   ex_wr = 1'b1; end
      default: ;
    endcase
  end

  // Operands bypass the register file when EX is writing the same register this cycle.
  assign id_a = (ex_wr && idex.rd == ifid.rd) ? ex_result : regs[ifid.rd];
  assign id_b = (ex_wr && idex.rd == ifid.rs) ? ex_result : regs[ifid.rs];

  always_comb begin
    pc_nx         = pc;
    ifid_nx       = '0;
    fetch_stop_nx = fetch_stop;
    if (bz_taken) begin
      pc_nx         = bz_target;
      fetch_stop_nx = 1'b0;
    end else if (fetch_stop || !bus.instr_valid_i) begin
      pc_nx = pc;
    end else if (f_op == OP_JMP) begin
      pc_nx = jmp_target;
    end else if (f_op == OP_HALT) begin
      ifid_nx.op    = OP_HALT;
      fetch_stop_nx = 1'b1;
    end else begin
      ifid_nx = '{op: f_op, rd: f_rd, rs: f_rs, imm: bus.imm_i, pc: pc};
      pc_nx   = pc + PC_W'(1);
    end
  end

  always_comb begin
    idex_nx = '0;
    if (!bz_taken)
      idex_nx = '{op: ifid.op, rd: ifid.rd, a: id_a, b: id_b, imm: ifid.imm, pc: ifid.pc};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      ifid       <= '0;
      idex       <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      halted     <= 1'b0;
    end else begin
      pc         <= pc_nx;
      fetch_stop <= fetch_stop_nx;
      ifid       <= ifid_nx;
      idex       <= idex_nx;
      wb_en      <= ex_wr;
      if (ex_wr) begin
        wb_addr <= idex.rd;
        wb_data <= ex_result;
      end
      if (idex.op == OP_HALT)
        halted <= 1'b1;
    end
  end

  // NOTE: the register file must read as zero after reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (ex_wr) begin
      regs[idex.rd] <= ex_result;
    end
  end

  assign bus.pc_o      = pc;
  assign bus.wb_en_o   = wb_en;
  assign bus.wb_addr_o = wb_addr;
  assign bus.wb_data_o = wb_data;
  assign bus.halted_o  = halted;
endmodule

// File: tb/tb_pipe3_core.sv
// Bench for pipe3_core (DATA_W=16, NREG=16, PC_W=8): directed pipeline-timing steps,
// then random forward-only programs compared against a sequential ISA interpreter.
module tb_pipe3_core;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int PW = 8;

  localparam logic [2:0] NOP = 3'd0, MOVI = 3'd1, ADDI = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, JMP = 3'd5, BZ = 3'd6, HALT = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_en = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [2:0]  p_op  [256];
  logic [3:0]  p_rd  [256];
  logic [3:0]  p_rs  [256];
  logic [15:0] p_imm [256];

  int exp_a[$], exp_d[$], got_a[$], got_d[$];
  int exp_halt_pc;

  pipe3_if #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) bus ();

  pipe3_core #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  always_comb begin
    bus.instr_i       = {p_op[bus.pc_o], p_rd[bus.pc_o], p_rs[bus.pc_o]};
    bus.imm_i         = p_imm[bus.pc_o];
    bus.instr_valid_i = valid_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic en, input int a, input int d);
    check({tag, "_en"}, bus.wb_en_o, en);
    if (en) begin
      check({tag, "_addr"}, bus.wb_addr_o, a);
      check({tag, "_data"}, bus.wb_data_o, d);
    end
  endtask

  task automatic begin_test();
    rst = 1'b1;
    valid_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      p_op[i] = HALT; p_rd[i] = '0; p_rs[i] = '0; p_imm[i] = '0;
    end
  endtask

  task automatic put(input int a, input logic [2:0] op, input int rd, input int rs,
                     input logic [15:0] imm);
    p_op[a] = op; p_rd[a] = 4'(rd); p_rs[a] = 4'(rs); p_imm[a] = imm;
  endtask

  // Reset is released at a falling edge; that cycle is cycle 0.
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic at(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Architectural interpreter: the pipeline must be indistinguishable from sequential execution.
  task automatic model_run();
    logic [15:0] r [16];
    logic [7:0]  pc = '0;
    for (int i = 0; i < 16; i++) r[i] = '0;
    exp_a.delete(); exp_d.delete();
    exp_halt_pc = -1;
    for (int step = 0; step < 1000; step++) begin
      case (p_op[pc])
        MOVI: begin r[p_rd[pc]] = p_imm[pc]; exp_a.push_back(p_rd[pc]); exp_d.push_back(r[p_rd[pc]]); pc++; end
        ADDI: begin r[p_rd[pc]] += p_imm[pc]; exp_a.push_back(p_rd[pc]); exp_d.push_back(r[p_rd[pc]]); pc++; end
        ADD:  begin r[p_rd[pc]] += r[p_rs[pc]]; exp_a.push_back(p_rd[pc]); exp_d.push_back(r[p_rd[pc]]); pc++; end
        SUB:  begin r[p_rd[pc]] -= r[p_rs[pc]]; exp_a.push_back(p_rd[pc]); exp_d.push_back(r[p_rd[pc]]); pc++; end
        JMP:  pc = pc + p_imm[pc][7:0];
        BZ:   pc = (r[p_rs[pc]] == 16'd0) ? pc + p_imm[pc][7:0] : pc + 8'd1;
        HALT: begin exp_halt_pc = pc; break; end
        default: pc++;
      endcase
    end
  endtask

  initial begin
    // Back-to-back dependent ALU ops with forwarding.
    begin_test();
    put(0, MOVI, 1, 0, 5); put(1, ADDI, 1, 0, 3); put(2, ADD, 2, 1, 0);
    release_rst();
    check("rst_pc", bus.pc_o, 0);
    check("rst_halted", bus.halted_o, 0);
    check("rst_wb_en", bus.wb_en_o, 0);
    check("rst_wb_addr", bus.wb_addr_o, 0);
    check("rst_wb_data", bus.wb_data_o, 0);
    at(3); chk_wb("fw_movi", 1, 1, 5);
    at(4); chk_wb("fw_addi", 1, 1, 8);
    at(5); chk_wb("fw_add", 1, 2, 8);

    // Taken BZ squashes the two younger instructions.
    begin_test();
    put(0, MOVI, 3, 0, 0); put(1, BZ, 0, 3, 4); put(2, ADDI, 4, 0, 1);
    put(3, ADDI, 4, 0, 1); put(4, NOP, 0, 0, 0); put(5, MOVI, 5, 0, 7);
    release_rst();
    at(3); chk_wb("bzt_movi", 1, 3, 0);
    at(4); check("bzt_pc", bus.pc_o, 5); chk_wb("bzt_sq0", 0, 0, 0);
    at(5); chk_wb("bzt_sq1", 0, 0, 0);
    at(6); chk_wb("bzt_sq2", 0, 0, 0);
    at(7); chk_wb("bzt_target", 1, 5, 7);

    // Untaken BZ: no bubbles.
    begin_test();
    put(0, MOVI, 3, 0, 9); put(1, BZ, 0, 3, 4); put(2, ADDI, 4, 0, 1); put(3, ADDI, 4, 0, 2);
    release_rst();
    at(3); chk_wb("bzn_movi", 1, 3, 9);
    at(4); chk_wb("bzn_bz", 0, 0, 0);
    at(5); chk_wb("bzn_addi1", 1, 4, 1);
    at(6); chk_wb("bzn_addi2", 1, 4, 3);

    // JMP -2 from pc 0 wraps to 254.
    begin_test();
    put(0, JMP, 0, 0, 16'hFFFE); put(254, MOVI, 6, 0, 16'h1234);
    release_rst();
    at(1); check("jmp_wrap_pc", bus.pc_o, 254);
    at(2); check("jmp_next_pc", bus.pc_o, 255);
    at(4); chk_wb("jmp_movi", 1, 6, 16'h1234);

    // Fetch stall while instr_valid_i is low for 3 cycles.
    begin_test();
    put(0, MOVI, 7, 0, 1); put(1, ADDI, 7, 0, 1); put(2, ADDI, 7, 0, 1);
    release_rst();
    at(1); valid_en = 1'b0; check("stall_pc1", bus.pc_o, 1);
    at(2); check("stall_pc2", bus.pc_o, 1);
    at(3); check("stall_pc3", bus.pc_o, 1); chk_wb("stall_movi", 1, 7, 1);
    at(4); valid_en = 1'b1; check("stall_pc4", bus.pc_o, 1); chk_wb("stall_nowb4", 0, 0, 0);
    at(5); check("stall_resume_pc", bus.pc_o, 2); chk_wb("stall_nowb5", 0, 0, 0);
    at(6); chk_wb("stall_nowb6", 0, 0, 0);
    at(7); chk_wb("stall_addi1", 1, 7, 2);
    at(8); chk_wb("stall_addi2", 1, 7, 3);

    // HALT at pc 6.
    begin_test();
    for (int i = 0; i < 6; i++) put(i, NOP, 0, 0, 0);
    put(7, MOVI, 1, 0, 99);
    release_rst();
    at(7); check("halt_pc7", bus.pc_o, 6);
    at(8); check("halt_not_yet", bus.halted_o, 0);
    at(9); check("halt_set", bus.halted_o, 1); check("halt_pc9", bus.pc_o, 6);
    at(12); check("halt_sticky", bus.halted_o, 1); check("halt_pc12", bus.pc_o, 6);
    chk_wb("halt_nowb", 0, 0, 0);

    // SUB 0-1 wraps, then asynchronous reset mid-stream clears everything.
    begin_test();
    put(0, MOVI, 2, 0, 16'h55); put(1, MOVI, 8, 0, 0); put(2, MOVI, 9, 0, 1); put(3, SUB, 8, 9, 0);
    release_rst();
    at(5); chk_wb("sub_movi", 1, 9, 1);
    at(6); chk_wb("sub_wrap", 1, 8, 16'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", bus.pc_o, 0);
    check("arst_wb_en", bus.wb_en_o, 0);
    check("arst_wb_addr", bus.wb_addr_o, 0);
    check("arst_wb_data", bus.wb_data_o, 0);
    check("arst_halted", bus.halted_o, 0);
    begin_test();
    put(0, ADDI, 2, 0, 0); put(1, ADD, 3, 8, 0);
    release_rst();
    at(3); chk_wb("arst_r2_zero", 1, 2, 0);
    at(4); chk_wb("arst_r8_zero", 1, 3, 0);

    // Random forward-only programs with random fetch stalls.
    for (int t = 0; t < 8; t++) begin
      begin_test();
      for (int a = 0; a < 40; a++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (op == JMP || op == BZ)
          put(a, op, $urandom_range(0, 15), $urandom_range(0, 15), 16'($urandom_range(1, 3)));
        else
          put(a, op, $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      end
      model_run();
      got_a.delete(); got_d.delete();
      release_rst();
      for (int c = 0; c < 3000 && !bus.halted_o; c++) begin
        @(negedge clk);
        if (bus.wb_en_o) begin
          got_a.push_back(int'(bus.wb_addr_o));
          got_d.push_back(int'(bus.wb_data_o));
        end
        valid_en = ($urandom_range(0, 3) != 0);
      end
      check("rnd_halted", bus.halted_o, 1);
      check("rnd_halt_pc", bus.pc_o, exp_halt_pc);
      check("rnd_wb_count", got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
        check("rnd_wb_addr", got_a[i], exp_a[i]);
        check("rnd_wb_data", got_d[i], exp_d[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
